axis_frame_arbiter: RTL and testbench
=====================================

Name: axis_frame_arbiter

Overview:
- Shares one AXI4-Stream master port between CH_NUM UI-style data sources.
- Grants one source for a whole frame of UI_FRAME_SIZE words, then re-arbitrates round-robin.
- Zero-extends UI data to the stream width, generates TLAST and TID, and honours TREADY backpressure.
- Sits between per-channel acquisition front ends and a single DMA/FIFO stream sink.

Parameters:
- CH_NUM, 4, number of requesting channels (2..16).
- UI_FRAME_SIZE, 1024, words per frame (>=2).
- UI_DATA_WIDTH, 16, UI data width per channel.
- C_M_AXIS_TDATA_WIDTH, 32, stream data width (>= UI_DATA_WIDTH, multiple of 8).
- ID_W, clog2(CH_NUM), width of TID and grant index (min 1).

Ports:
- M_AXIS_ACLK  in  1  clock.
- M_AXIS_ARESET  in  1  asynchronous reset, active-high.
- i_ch_en  in  CH_NUM  per-channel enable; sampled only at arbitration.
- i_ui_dvld  in  CH_NUM  per-channel data valid.
- i_ui_data  in  CH_NUM*UI_DATA_WIDTH  packed data; channel k occupies bits [k*UI_DATA_WIDTH +: UI_DATA_WIDTH].
- o_ui_drdy  out  CH_NUM  per-channel ready; at most one bit set.
- o_grant  out  ID_W  index of the current/last granted channel.
- o_busy  out  1  high while in SEND.
- o_frame_done  out  1  one-cycle pulse when the TLAST beat is accepted downstream.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  zero-extended UI data.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all ones.
- M_AXIS_TLAST  out  1  last word of frame.
- M_AXIS_TID  out  ID_W  source channel of the beat.
- M_AXIS_TREADY  in  1  stream ready.

Behaviour:
Reset:
- Async assert clears state to IDLE and sets TVALID/TLAST/TDATA/TID = 0, o_ui_drdy = 0, o_busy = 0, o_frame_done = 0, word counter = 0.
- o_grant and the last-grant register reset to CH_NUM-1, so channel 0 has first priority.
- Reset mid-frame discards the partial frame; there is no resume.

States:
- IDLE
  - req = i_ch_en & i_ui_dvld.
  - If req != 0, choose the first set bit searching from (last_grant+1) mod CH_NUM upward with wrap.
  - Load grant, go to SEND.
  - If req == 0, stay in IDLE.
- SEND
  - o_ui_drdy[grant] = !M_AXIS_TVALID || M_AXIS_TREADY; all other bits 0.
  - Input beat accepted when o_ui_drdy[grant] && i_ui_dvld[grant].
  - On acceptance, the output register loads TDATA = zero-extended data, TID = grant, TVALID = 1, TLAST = (cnt == UI_FRAME_SIZE-1); cnt increments.
  - When the beat with cnt == UI_FRAME_SIZE-1 is accepted, cnt returns to 0 and the state goes to DRAIN.
- DRAIN
  - o_ui_drdy = 0.
  - Wait until the TLAST beat is accepted downstream (TVALID && TREADY && TLAST), then go to IDLE.
  - o_frame_done pulses in that same cycle.

Output register:
- If TVALID && TREADY and no new input beat is accepted, clear TVALID and TLAST next cycle.
- TDATA/TID hold their value while TVALID && !TREADY.

Timing:
- Latency: input accept to TVALID is 1 cycle.
- Arbitration costs 1 IDLE cycle per frame.
- Sustained throughput is 1 word/cycle within a frame when TREADY = 1.

Boundary conditions:
- Input dvld dropping mid-frame: the grant is held and the block waits indefinitely; there is no timeout.
- i_ch_en deasserted mid-frame: the frame still completes.
- A channel with dvld low at arbitration is skipped.
- Simultaneous requests are resolved purely by rotation.
- Counter width is clog2(UI_FRAME_SIZE); the counter is compared, not relied on to wrap.

Test Plan (bench with UI_FRAME_SIZE=4, CH_NUM=4, UI_DATA_WIDTH=16, C_M_AXIS_TDATA_WIDTH=32):
1. Single channel
   - Stimulus: ch2 only, dvld=1 continuously, data 0x0A01..0x0A04, TREADY=1.
   - Response: 4 beats on consecutive cycles, TDATA 0x00000A01..0x00000A04, TID=2, TLAST only on the 4th, o_frame_done one cycle later; next frame starts after 1 IDLE cycle.
2. Round-robin fairness
   - Stimulus: all 4 channels valid continuously.
   - Response: frames granted in order 0,1,2,3,0; each frame is exactly 4 beats with a constant TID.
3. Backpressure
   - Stimulus: ch1 frame, TREADY toggled 1,0,0,1,...
   - Response: TDATA/TID/TLAST stable while stalled, no beat lost or duplicated, o_ui_drdy[1] low whenever TVALID && !TREADY.
4. Source gap and enable
   - Stimulus: ch0 dvld low for 3 cycles after word 2; i_ch_en[0] cleared during the gap.
   - Response: grant held, frame completes with 4 beats and TLAST; ch0 is skipped at the next arbitration.
5. Async reset mid-frame
   - Stimulus: assert M_AXIS_ARESET after beat 2 of a ch3 frame.
   - Response: TVALID/TLAST/o_ui_drdy go 0 immediately (without waiting for a clock edge); after release the first grant goes to ch0 and the counter restarts at 0.
6. Skip-idle rotation
   - Stimulus: last grant = 3; only ch1 and ch3 valid.
   - Response: ch1 is granted next, then ch3.

Source files
------------

// File: rtl/axis_frame_arbiter_if.sv
// AXI4-Stream bundle between the frame arbiter and its stream sink.
interface axis_frame_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 2
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic                  tlast;
    logic [ID_W-1:0]       tid;

    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        output tid,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        input  tid,
        output tready
    );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Round-robin frame arbiter: grants one UI source for a whole frame and
// serialises its words onto a single AXI4-Stream master port.
module axis_frame_arbiter #(
    parameter int unsigned CH_NUM               = 4,
    parameter int unsigned UI_FRAME_SIZE        = 1024,
    parameter int unsigned UI_DATA_WIDTH        = 16,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    localparam int unsigned ID_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESET,
    input  logic [CH_NUM-1:0]                 i_ch_en,
    input  logic [CH_NUM-1:0]                 i_ui_dvld,
    input  logic [CH_NUM*UI_DATA_WIDTH-1:0]   i_ui_data,
    output logic [CH_NUM-1:0]                 o_ui_drdy,
    output logic [ID_W-1:0]                   o_grant,
    output logic                              o_busy,
    output logic                              o_frame_done,
    axis_frame_arbiter_if.master              m_axis
);

    localparam int unsigned CNT_W = $clog2(UI_FRAME_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(UI_FRAME_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StSend, StDrain} state_e;

    state_e                          state_q;
    logic [ID_W-1:0]                 grant_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            tvalid_q;
    logic                            tlast_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic [ID_W-1:0]                 tid_q;
    logic                            frame_done_q;

    logic [CH_NUM-1:0]               req;
    logic                            lo_found;
    logic                            hi_found;
    logic [ID_W-1:0]                 lo_idx;
    logic [ID_W-1:0]                 hi_idx;
    logic [UI_DATA_WIDTH-1:0]        sel_data;
    logic                            sel_dvld;
    logic                            slot_free;
    logic                            accept;
    logic                            last_word;
    logic                            tlast_taken;

    assign req = i_ch_en & i_ui_dvld;

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (ID_W'(i) > grant_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_dvld = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ID_W'(i) == grant_q) begin
                sel_data = i_ui_data[i*UI_DATA_WIDTH +: UI_DATA_WIDTH];
                sel_dvld = i_ui_dvld[i];
            end
        end
    end

    assign slot_free   = !tvalid_q || m_axis.tready;
    assign accept      = (state_q == StSend) && slot_free && sel_dvld;
    assign last_word   = (cnt_q == LAST_CNT);
    assign tlast_taken = tvalid_q && m_axis.tready && tlast_q;

    always_comb begin
        o_ui_drdy = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            o_ui_drdy[i] = (state_q == StSend) && (ID_W'(i) == grant_q) && slot_free;
        end
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q      <= StIdle;
            grant_q      <= ID_W'(CH_NUM - 1);
            cnt_q        <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
            tid_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (accept) begin
                tdata_q  <= C_M_AXIS_TDATA_WIDTH'(sel_data);
                tid_q    <= grant_q;
                tvalid_q <= 1'b1;
                tlast_q  <= last_word;
            end else if (tvalid_q && m_axis.tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (lo_found) begin
                        grant_q <= hi_found ? hi_idx : lo_idx;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (accept) begin
                        if (last_word) begin
                            cnt_q   <= '0;
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (tlast_taken) begin
                        frame_done_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_grant       = grant_q;
    assign o_busy        = (state_q == StSend);
    assign o_frame_done  = frame_done_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tstrb  = '1;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tid    = tid_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: 4 channels, 4-word frames, 16-bit UI into 32-bit stream.
module tb_axis_frame_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  dvld;
    logic [63:0] ui_data;
    logic [3:0]  drdy;
    logic [1:0]  grant;
    logic        busy;
    logic        frame_done;
    logic        tready;

    logic [15:0] base [4];
    int          widx [4];
    int          cyc;
    int          errors;
    int          checks;

    logic [31:0] bd [$];
    logic [1:0]  bi [$];
    logic        bl [$];
    int          bc [$];
    int          fd [$];

    logic        s_tvalid, s_tready, s_tlast, s_busy;
    logic [31:0] s_tdata;
    logic [1:0]  s_tid, s_grant;
    logic [3:0]  s_drdy;

    axis_frame_arbiter_if #(.DATA_W(32), .ID_W(2)) axis ();

    assign axis.tready = tready;

    axis_frame_arbiter #(
        .CH_NUM               (4),
        .UI_FRAME_SIZE        (4),
        .UI_DATA_WIDTH        (16),
        .C_M_AXIS_TDATA_WIDTH (32)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .i_ch_en       (en),
        .i_ui_dvld     (dvld),
        .i_ui_data     (ui_data),
        .o_ui_drdy     (drdy),
        .o_grant       (grant),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .m_axis        (axis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh_data();
        for (int c = 0; c < 4; c++) ui_data[c*16 +: 16] = base[c] + 16'(widx[c]);
    endtask

    // One clock: sample at the falling edge, advance sources, return 1 time unit after the rise.
    task automatic cycle();
        @(negedge clk);
        s_tvalid = axis.tvalid;
        s_tready = axis.tready;
        s_tdata  = axis.tdata;
        s_tid    = axis.tid;
        s_tlast  = axis.tlast;
        s_drdy   = drdy;
        s_grant  = grant;
        s_busy   = busy;
        if (axis.tvalid && axis.tready) begin
            bd.push_back(axis.tdata);
            bi.push_back(axis.tid);
            bl.push_back(axis.tlast);
            bc.push_back(cyc);
        end
        if (frame_done) fd.push_back(cyc);
        for (int c = 0; c < 4; c++) if (drdy[c] && dvld[c]) widx[c]++;
        cyc++;
        @(posedge clk);
        #1;
        refresh_data();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        en     = '0;
        dvld   = '0;
        tready = 1'b1;
        for (int c = 0; c < 4; c++) widx[c] = 0;
        bd.delete(); bi.delete(); bl.delete(); bc.delete(); fd.delete();
        refresh_data();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (axis.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", axis.tvalid);
        else checks += 0;
        if (axis.tvalid !== 1'b0) errors++;
        checks++; if (axis.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", axis.tlast); end
        checks++; if (axis.tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h expected 0", axis.tdata); end
        checks++; if (axis.tid !== 2'd0) begin errors++; $display("FAIL rst_tid: got %0d expected 0", axis.tid); end
        checks++; if (drdy !== 4'b0) begin errors++; $display("FAIL rst_drdy: got %b expected 0000", drdy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", frame_done); end
        checks++; if (grant !== 2'd3) begin errors++; $display("FAIL rst_grant: got %0d expected 3", grant); end
        checks++; if (axis.tstrb !== 4'hF) begin errors++; $display("FAIL tstrb: got %h expected f", axis.tstrb); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle();
        checks++; if (s_busy !== 1'b0 || s_tvalid !== 1'b0 || s_grant !== 2'd3) begin
            errors++;
            $display("FAIL idle_no_req: got busy=%b tvalid=%b grant=%0d expected 0 0 3",
                     s_busy, s_tvalid, s_grant);
        end
    endtask

    task automatic test_single();
        int n;
        base[2] = 16'h0A01;
        do_reset();
        en = 4'b0100; dvld = 4'b0100;
        n = 0;
        while (bd.size() < 8 && n < 60) begin cycle(); n++; end
        en = '0; dvld = '0;
        repeat (3) cycle();
        checks++;
        if (bd.size() != 8) begin
            errors++; $display("FAIL t1_beats: got %0d expected 8", bd.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (bd[i] !== 32'h0A01 + 32'(i)) begin
                    errors++; $display("FAIL t1_tdata[%0d]: got %h expected %h", i, bd[i], 32'h0A01 + i);
                end
                checks++; if (bi[i] !== 2'd2) begin
                    errors++; $display("FAIL t1_tid[%0d]: got %0d expected 2", i, bi[i]);
                end
                checks++; if (bl[i] !== (i % 4 == 3)) begin
                    errors++; $display("FAIL t1_tlast[%0d]: got %b expected %b", i, bl[i], i % 4 == 3);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++; if (bc[i] != bc[i-1] + 1) begin
                    errors++; $display("FAIL t1_consec[%0d]: got gap %0d expected 1", i, bc[i] - bc[i-1]);
                end
            end
            checks++; if (bc[4] != bc[3] + 3) begin
                errors++; $display("FAIL t1_rearb_gap: got %0d expected 3", bc[4] - bc[3]);
            end
            checks++; if (fd.size() != 2 || fd[0] != bc[3] + 1) begin
                errors++; $display("FAIL t1_frame_done: got count %0d expected 2 at beat4+1", fd.size());
            end
        end
    endtask

    task automatic test_round_robin();
        int n;
        int ch;
        logic [31:0] exp_d;
        base[0] = 16'h1100; base[1] = 16'h2200; base[2] = 16'h3300; base[3] = 16'h4400;
        do_reset();
        en = 4'b1111; dvld = 4'b1111;
        n = 0;
        while (bd.size() < 20 && n < 120) begin cycle(); n++; end
        en = '0; dvld = '0;
        repeat (3) cycle();
        checks++;
        if (bd.size() != 20) begin
            errors++; $display("FAIL t2_beats: got %0d expected 20", bd.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                ch    = (i / 4) % 4;
                exp_d = 32'(base[ch]) + 32'(((i / 4) / 4) * 4 + i % 4);
                checks++; if (bi[i] !== 2'(ch)) begin
                    errors++; $display("FAIL t2_tid[%0d]: got %0d expected %0d", i, bi[i], ch);
                end
                checks++; if (bd[i] !== exp_d) begin
                    errors++; $display("FAIL t2_tdata[%0d]: got %h expected %h", i, bd[i], exp_d);
                end
                checks++; if (bl[i] !== (i % 4 == 3)) begin
                    errors++; $display("FAIL t2_tlast[%0d]: got %b expected %b", i, bl[i], i % 4 == 3);
                end
            end
            for (int f = 1; f < 5; f++) begin
                checks++; if (bc[4*f] != bc[4*f-1] + 3) begin
                    errors++; $display("FAIL t2_gap[%0d]: got %0d expected 3", f, bc[4*f] - bc[4*f-1]);
                end
            end
            checks++; if (fd.size() != 5) begin
                errors++; $display("FAIL t2_done_count: got %0d expected 5", fd.size());
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int stalls;
        logic [3:0]  pat;
        logic        p_tvalid, p_tready, p_tlast;
        logic [31:0] p_tdata;
        logic [1:0]  p_tid;
        base[1] = 16'hB000;
        do_reset();
        pat = 4'b1001;
        en = 4'b0010; dvld = 4'b0010;
        p_tvalid = 1'b0; p_tready = 1'b1; p_tlast = 1'b0; p_tdata = '0; p_tid = '0;
        n = 0;
        stalls = 0;
        while (bd.size() < 4 && n < 80) begin
            tready = pat[n % 4];
            cycle();
            n++;
            if (p_tvalid && !p_tready) begin
                stalls++;
                checks++;
                if (s_tvalid !== 1'b1 || s_tdata !== p_tdata || s_tid !== p_tid || s_tlast !== p_tlast) begin
                    errors++;
                    $display("FAIL t3_stall_hold: got v=%b d=%h id=%0d l=%b expected v=1 d=%h id=%0d l=%b",
                             s_tvalid, s_tdata, s_tid, s_tlast, p_tdata, p_tid, p_tlast);
                end
            end
            if (s_tvalid && !s_tready) begin
                checks++; if (s_drdy[1] !== 1'b0) begin
                    errors++; $display("FAIL t3_drdy_stalled: got %b expected 0", s_drdy[1]);
                end
            end
            p_tvalid = s_tvalid; p_tready = s_tready; p_tlast = s_tlast;
            p_tdata  = s_tdata;  p_tid    = s_tid;
        end
        en = '0; dvld = '0; tready = 1'b1;
        repeat (3) cycle();
        checks++; if (stalls == 0) begin
            errors++; $display("FAIL t3_stalls_seen: got 0 expected >0");
        end
        checks++;
        if (bd.size() != 4) begin
            errors++; $display("FAIL t3_beats: got %0d expected 4", bd.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (bd[i] !== 32'hB000 + 32'(i) || bi[i] !== 2'd1 || bl[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL t3_beat[%0d]: got d=%h id=%0d l=%b expected d=%h id=1 l=%b",
                             i, bd[i], bi[i], bl[i], 32'hB000 + i, i == 3);
                end
            end
        end
        checks++; if (fd.size() != 1) begin
            errors++; $display("FAIL t3_done_count: got %0d expected 1", fd.size());
        end
    endtask

    task automatic test_gap_enable();
        int n;
        logic [1:0]  exp_id [3];
        logic [31:0] exp_d;
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd1;
        base[0] = 16'hC000; base[1] = 16'hD000;
        do_reset();
        en = 4'b0011; dvld = 4'b0011;
        n = 0;
        while (widx[0] < 2 && n < 40) begin cycle(); n++; end
        dvld[0] = 1'b0; en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++; if (s_grant !== 2'd0 || s_busy !== 1'b1) begin
                errors++; $display("FAIL t4_hold[%0d]: got grant=%0d busy=%b expected 0 1", k, s_grant, s_busy);
            end
        end
        dvld[0] = 1'b1;
        n = 0;
        while (bd.size() < 12 && n < 80) begin cycle(); n++; end
        en = '0; dvld = '0;
        repeat (3) cycle();
        checks++;
        if (bd.size() != 12) begin
            errors++; $display("FAIL t4_beats: got %0d expected 12", bd.size());
        end else begin
            checks++; if (bc[2] != bc[1] + 4) begin
                errors++; $display("FAIL t4_gap: got %0d expected 4", bc[2] - bc[1]);
            end
            for (int i = 0; i < 12; i++) begin
                exp_d = (i < 4) ? 32'hC000 + 32'(i) : 32'hD000 + 32'(i - 4);
                checks++;
                if (bi[i] !== exp_id[i/4] || bd[i] !== exp_d || bl[i] !== (i % 4 == 3)) begin
                    errors++;
                    $display("FAIL t4_beat[%0d]: got d=%h id=%0d l=%b expected d=%h id=%0d l=%b",
                             i, bd[i], bi[i], bl[i], exp_d, exp_id[i/4], i % 4 == 3);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        base[0] = 16'h5A00; base[3] = 16'hE000;
        do_reset();
        en = 4'b1000; dvld = 4'b1000;
        n = 0;
        while (bd.size() < 2 && n < 40) begin cycle(); n++; end
        checks++; if (bd.size() != 2) begin
            errors++; $display("FAIL t5_pre_beats: got %0d expected 2", bd.size());
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0 || drdy !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_async_clear: got v=%b l=%b drdy=%b busy=%b expected 0 0 0000 0",
                     axis.tvalid, axis.tlast, drdy, busy);
        end
        @(posedge clk);
        #1;
        bd.delete(); bi.delete(); bl.delete(); bc.delete(); fd.delete();
        for (int c = 0; c < 4; c++) widx[c] = 0;
        refresh_data();
        en = 4'b1001; dvld = 4'b1001;
        rst = 1'b0;
        n = 0;
        while (bd.size() < 4 && n < 40) begin cycle(); n++; end
        en = '0; dvld = '0;
        repeat (3) cycle();
        checks++;
        if (bd.size() != 4) begin
            errors++; $display("FAIL t5_beats: got %0d expected 4", bd.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (bi[i] !== 2'd0 || bd[i] !== 32'h5A00 + 32'(i) || bl[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL t5_beat[%0d]: got d=%h id=%0d l=%b expected d=%h id=0 l=%b",
                             i, bd[i], bi[i], bl[i], 32'h5A00 + i, i == 3);
                end
            end
        end
    endtask

    task automatic test_skip_idle();
        int n;
        logic [31:0] exp_d;
        base[1] = 16'h6100; base[3] = 16'h6300;
        do_reset();
        checks++; if (grant !== 2'd3) begin
            errors++; $display("FAIL t6_start_grant: got %0d expected 3", grant);
        end
        en = 4'b1010; dvld = 4'b1010;
        n = 0;
        while (bd.size() < 8 && n < 60) begin cycle(); n++; end
        en = '0; dvld = '0;
        repeat (3) cycle();
        checks++;
        if (bd.size() != 8) begin
            errors++; $display("FAIL t6_beats: got %0d expected 8", bd.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_d = (i < 4) ? 32'h6100 + 32'(i) : 32'h6300 + 32'(i - 4);
                checks++;
                if (bi[i] !== ((i < 4) ? 2'd1 : 2'd3) || bd[i] !== exp_d || bl[i] !== (i % 4 == 3)) begin
                    errors++;
                    $display("FAIL t6_beat[%0d]: got d=%h id=%0d l=%b expected d=%h id=%0d l=%b",
                             i, bd[i], bi[i], bl[i], exp_d, (i < 4) ? 1 : 3, i % 4 == 3);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        rst    = 1'b0;
        en     = '0;
        dvld   = '0;
        tready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            base[c] = '0;
            widx[c] = 0;
        end
        refresh_data();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_gap_enable();
        test_async_reset();
        test_skip_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
